mac_accumulator: RTL and testbench
==================================

Name: mac_accumulator

Overview:
- Streaming signed multiply-accumulate stage for dot products in the accelerator datapath.
- Registers operand pairs and feeds them as {a, b} into the combinational 8x8 Booth multiplier; `a` is the upper half, `b` the lower half.
- Accumulates the signed products of each vector and emits one result per vector, marked by in_last.
- Valid/ready on both sides; optional saturation.

Parameters:
- BITS, 8, operand width; the multiplier instance is built for BITS=8, even values only.
- ACC_BITS, 24, accumulator and result width; must be >= 2*BITS.
- SATURATE, 1, 1 = clamp to signed ACC_BITS range, 0 = two's-complement wrap.

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept a pair.
- in_a  input  BITS  signed multiplicand, upper half of multiplier input.
- in_b  input  BITS  signed multiplier, lower half of multiplier input.
- in_last  input  1  pair is the final element of its vector.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  ACC_BITS  signed dot-product result.
- out_sat  output  1  overflow occurred while accumulating this vector.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_sat=0, all stage valid bits 0, accumulator 0, sticky overflow 0.
  - in_ready is 1 out of reset.
- Global stall: stall = out_valid && !out_ready.
  - in_ready = !stall (combinational).
  - While stalled, every register holds and out_data/out_sat stay stable.
- S1 (operand register): on in_valid && in_ready, capture in_a, in_b, in_last and set s1_valid.
  - Otherwise a bubble (s1_valid=0) advances.
- Multiplier: combinational on {s1_a, s1_b}; 2*BITS-bit signed product.
- S2 (product register): captures the product, s1_valid and s1_last.
  - The product is sign-extended to ACC_BITS+1 for the add.
- Accumulate on an S2 beat: sum = acc + product in ACC_BITS+1 bits.
  - Overflow when sum lies outside the signed ACC_BITS range.
  - SATURATE=1: result clamps to 2^(ACC_BITS-1)-1 or -2^(ACC_BITS-1).
  - SATURATE=0: result is the sum truncated to ACC_BITS.
  - Overflow ORs into the per-vector sticky flag.
- Beat without last: acc <= result; sticky updated.
- Beat with last:
  - out_data <= result.
  - out_sat <= sticky | this beat's overflow.
  - out_valid <= 1.
  - acc <= 0 and sticky <= 0, so the next vector starts clean in the following cycle.
- Latency: a last pair accepted in cycle T gives out_valid=1 in cycle T+3 when there is no stall.
- Throughput: one pair per cycle.
- Output handshake:
  - out_valid && out_ready with no new result → out_valid <= 0.
  - Same cycle as a new last beat → the new result loads and out_valid stays 1.
- Single-element vector: out_data = that product.
- Bubbles (in_valid=0) never touch acc.
- Reset mid-vector: partial sum and in-flight pairs are discarded; the next accepted pair starts a new vector.
- in_last is sampled only on accepted pairs.
- Multiplier range: -128*-128 = 16384 fits in 16 bits signed, so the product itself never wraps.

Test Plan:
- Basic dot product: a=[1,2,3,4], b=[5,6,7,8], last on the 4th pair, out_ready=1 → out_data=70, out_sat=0, out_valid exactly 3 cycles after the 4th acceptance, single pulse.
- Signed corners: single-element vectors (-128,-128), (-128,127), (0,-5), each with last → results 16384, -16256, 0, each with out_sat=0.
- Backpressure: vector [3]*[3] completes, out_ready held 0 for 5 cycles while in_valid=1 → in_ready=0, out_data=9 stable; release → next vector [2,2]*[5,5] gives 20, no pair lost or duplicated.
- Saturation, ACC_BITS=16:
  - SATURATE=1, three pairs 127*127 → out_data=32767, out_sat=1; following vector [1]*[1] → 1, out_sat=0.
  - SATURATE=0 → out_data=-17149, out_sat=1.
- Reset mid-vector: two pairs (10,10) accepted, then rst pulsed, then [2]*[3] with last → out_data=6; outputs 0 during and after reset.
- Back-to-back with gaps: vectors [1]*[1] last, immediately [4,-4]*[2,2] last, random in_valid bubbles, out_ready=1 → results 1 then 0, in order, no cross-vector leakage.

Source files
------------

// File: rtl/mac_accumulator.sv
// Streaming signed multiply-accumulate: operand register, radix-4 Booth multiplier,
// product register and a saturating/wrapping accumulator emitting one result per vector.

module mac_booth_mul #(
  parameter int unsigned BITS = 8
) (
  input  logic [2*BITS-1:0] ab,
  output logic [2*BITS-1:0] prod
);
  localparam int unsigned PW     = 2 * BITS;
  localparam int unsigned DIGITS = BITS / 2;

  logic [BITS-1:0] a;
  logic [BITS-1:0] b;
  logic [BITS:0]   bx;
  logic [PW-1:0]   ae;
  logic [PW-1:0]   pp;
  logic [PW-1:0]   sum;
  logic [2:0]      dig;

  assign a  = ab[PW-1:BITS];
  assign b  = ab[BITS-1:0];
  assign bx = {b, 1'b0};

  // Radix-4 Booth recoding: each overlapping 3-bit window selects 0, +-a or +-2a.
  always_comb begin
    ae  = PW'($signed(a));
    pp  = '0;
    sum = '0;
    dig = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = bx[2*i +: 3];
      case (dig)
        3'b001, 3'b010: pp = ae;
        3'b011:         pp = ae << 1;
        3'b100:         pp = -(ae << 1);
        3'b101, 3'b110: pp = -ae;
        default:        pp = '0;
      endcase
      sum = sum + (pp << (2*i));
    end
    prod = sum;
  end
endmodule

module mac_accumulator #(
  parameter int unsigned BITS     = 8,
  parameter int unsigned ACC_BITS = 24,
  parameter int unsigned SATURATE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITS-1:0]     in_a,
  input  logic [BITS-1:0]     in_b,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_BITS-1:0] out_data,
  output logic                out_sat
);
  localparam int unsigned PW = 2 * BITS;
  localparam int unsigned SW = ACC_BITS + 1;

  logic                stall;
  logic                s1_valid;
  logic                s1_last;
  logic [BITS-1:0]     s1_a;
  logic [BITS-1:0]     s1_b;
  logic [PW-1:0]       prod;
  logic                s2_valid;
  logic                s2_last;
  logic [PW-1:0]       s2_prod;
  logic [ACC_BITS-1:0] acc;
  logic                sticky;
  logic [SW-1:0]       sum;
  logic                ovf;
  logic [ACC_BITS-1:0] result;

  // A held result freezes the whole pipeline.
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  mac_booth_mul #(.BITS(BITS)) u_mul (
    .ab   ({s1_a, s1_b}),
    .prod (prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a    <= in_a;
        s1_b    <= in_b;
        s1_last <= in_last;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_prod  <= '0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_prod  <= prod;
    end
  end

  // One guard bit above the accumulator exposes overflow as a sign disagreement.
  always_comb begin
    sum    = SW'($signed(acc)) + SW'($signed(s2_prod));
    ovf    = sum[ACC_BITS] ^ sum[ACC_BITS-1];
    result = sum[ACC_BITS-1:0];
    if (ovf && (SATURATE != 0)) begin
      result = sum[ACC_BITS] ? {1'b1, {(ACC_BITS-1){1'b0}}}
                             : {1'b0, {(ACC_BITS-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      sticky    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (!stall) begin
      if (s2_valid && s2_last) begin
        out_data  <= result;
        out_sat   <= sticky | ovf;
        out_valid <= 1'b1;
        acc       <= '0;
        sticky    <= 1'b0;
      end else begin
        out_valid <= 1'b0;
        if (s2_valid) begin
          acc    <= result;
          sticky <= sticky | ovf;
        end
      end
    end
  end
endmodule

// File: tb/tb_mac_accumulator.sv
// Checks three mac_accumulator configurations (24-bit saturating, 16-bit saturating,
// 16-bit wrapping) driven in lockstep: directed vector table, corner sequences, random traffic.

module tb_mac_accumulator;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        ir0, ir1, ir2;
  logic        ov0, ov1, ov2;
  logic        os0, os1, os2;
  logic [23:0] od0;
  logic [15:0] od1, od2;

  always #5 clk = ~clk;

  mac_accumulator #(.BITS(8), .ACC_BITS(24), .SATURATE(1)) dut24 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_sat(os0));
  mac_accumulator #(.BITS(8), .ACC_BITS(16), .SATURATE(1)) dut16s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_sat(os1));
  mac_accumulator #(.BITS(8), .ACC_BITS(16), .SATURATE(0)) dut16w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_sat(os2));

  typedef struct packed {
    logic [2:0][31:0] d;
    logic [2:0]       s;
  } exp_t;

  typedef struct packed {
    logic [2:0]      n;
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    exp_t            e;
  } vec_t;

  int     n_vec = 0;
  int     n_err = 0;
  exp_t   exp_q[$];
  bit     mdl_en = 1'b0;
  longint macc[3];
  bit     mst[3];
  vec_t   tbl[10];

  task automatic check(input string name, input longint act, input longint expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired, got no event expected one", name);
  endtask

  function automatic longint got_d(input int c);
    case (c)
      0:       return longint'($signed(od0));
      1:       return longint'($signed(od1));
      default: return longint'($signed(od2));
    endcase
  endfunction

  function automatic bit got_s(input int c);
    case (c)
      0:       return os0;
      1:       return os1;
      default: return os2;
    endcase
  endfunction

  function automatic bit got_v(input int c);
    case (c)
      0:       return ov0;
      1:       return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic vec_t mk(input int n, input int a0, input int a1, input int a2, input int a3,
                              input int b0, input int b1, input int b2, input int b3,
                              input int e0, input bit s0, input int e1, input bit s1,
                              input int e2, input bit s2);
    vec_t v;
    v.n = 3'(n);
    v.a[0] = 8'(a0); v.a[1] = 8'(a1); v.a[2] = 8'(a2); v.a[3] = 8'(a3);
    v.b[0] = 8'(b0); v.b[1] = 8'(b1); v.b[2] = 8'(b2); v.b[3] = 8'(b3);
    v.e.d[0] = 32'(e0); v.e.d[1] = 32'(e1); v.e.d[2] = 32'(e2);
    v.e.s[0] = s0;      v.e.s[1] = s1;      v.e.s[2] = s2;
    return v;
  endfunction

  // Reference: dot product with per-step overflow handling, by integer arithmetic.
  task automatic model_accept(input logic [7:0] a, input logic [7:0] b, input bit l);
    longint p, sum, mx, mn, r, w;
    bit     of;
    exp_t   e;
    p = longint'($signed(a)) * longint'($signed(b));
    e = '0;
    for (int c = 0; c < 3; c++) begin
      w   = (c == 0) ? 24 : 16;
      mx  = (longint'(1) << (w - 1)) - 1;
      mn  = -mx - 1;
      sum = macc[c] + p;
      of  = (sum > mx) || (sum < mn);
      r   = sum;
      if (of) begin
        if (c != 2) r = (sum > mx) ? mx : mn;
        else        r = (sum > mx) ? sum - (longint'(1) << w) : sum + (longint'(1) << w);
      end
      if (l) begin
        e.d[c]  = 32'(r);
        e.s[c]  = mst[c] | of;
        macc[c] = 0;
        mst[c]  = 1'b0;
      end else begin
        macc[c] = r;
        mst[c]  = mst[c] | of;
      end
    end
    if (l) exp_q.push_back(e);
  endtask

  // One clock: drive at posedge+1, sample at negedge, score any result leaving.
  task automatic cycle(input bit v, input logic [7:0] a, input logic [7:0] b, input bit l,
                       input bit r, output bit acc);
    exp_t e;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_last   = l;
    out_ready = r;
    @(negedge clk);
    acc = v && ir0;
    if (mdl_en && acc) model_accept(a, b, l);
    if (mdl_en && ov0 && out_ready) begin
      if (exp_q.size() == 0) fail_now("unexpected_result");
      else begin
        e = exp_q.pop_front();
        for (int c = 0; c < 3; c++) begin
          check($sformatf("rand_data%0d", c), got_d(c), longint'($signed(e.d[c])));
          check($sformatf("rand_sat%0d", c), longint'(got_s(c)), longint'(e.s[c]));
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input bit l, input bit r);
    bit acc;
    acc = 1'b0;
    for (int k = 0; k < 100 && !acc; k++) cycle(1'b1, a, b, l, r, acc);
    if (!acc) fail_now("accept");
  endtask

  // Wait for the result of a last pair just accepted; it must appear on the third cycle.
  task automatic get_result(input exp_t e, input string tag);
    int     lat;
    longint d[3];
    bit     s[3];
    lat = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (ov0) begin
        lat = n;
        for (int c = 0; c < 3; c++) begin
          d[c] = got_d(c);
          s[c] = got_s(c);
          check({tag, "_valid_all"}, longint'(got_v(c)), 1);
        end
      end
      @(posedge clk);
      #1;
      if (lat != 0) break;
    end
    if (lat == 0) fail_now({tag, "_timeout"});
    else begin
      check({tag, "_latency"}, lat, 3);
      for (int c = 0; c < 3; c++) begin
        check($sformatf("%s_data%0d", tag, c), d[c], longint'($signed(e.d[c])));
        check($sformatf("%s_sat%0d", tag, c), longint'(s[c]), longint'(e.s[c]));
      end
      @(negedge clk);
      check({tag, "_single_pulse"}, longint'(ov0), 0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic gap();
    bit acc;
    repeat ($urandom_range(0, 2)) cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   acc;
    bit   seen;
    exp_t e;
    logic [7:0] ra, rb;

    tbl[0] = mk(4,    1,    2,    3,    4,   5,   6,    7,   8,     70, 0,     70, 0,     70, 0);
    tbl[1] = mk(1, -128,    0,    0,    0, -128,  0,    0,   0,  16384, 0,  16384, 0,  16384, 0);
    tbl[2] = mk(1, -128,    0,    0,    0, 127,   0,    0,   0, -16256, 0, -16256, 0, -16256, 0);
    tbl[3] = mk(1,    0,    0,    0,    0,  -5,   0,    0,   0,      0, 0,      0, 0,      0, 0);
    tbl[4] = mk(3,  127,  127,  127,    0, 127, 127,  127,   0,  48387, 0,  32767, 1, -17149, 1);
    tbl[5] = mk(1,    1,    0,    0,    0,   1,   0,    0,   0,      1, 0,      1, 0,      1, 0);
    tbl[6] = mk(3, -128, -128, -128,    0, 127, 127,  127,   0, -48768, 0, -32768, 1,  16768, 1);
    tbl[7] = mk(4,  127,  127,  127, -128, 127, 127,  127, 127,  32131, 0,  16511, 1,  32131, 1);
    tbl[8] = mk(2,    2,    2,    0,    0,   5,   5,    0,   0,     20, 0,     20, 0,     20, 0);
    tbl[9] = mk(4,   -7,  100,   -1,   55,   9,  -3, -128,   2,   -125, 0,   -125, 0,   -125, 0);

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      check("rst_valid", longint'(got_v(c)), 0);
      check("rst_data", got_d(c), 0);
      check("rst_sat", longint'(got_s(c)), 0);
    end
    check("rst_in_ready", longint'(ir0), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed vector table, consumer always ready.
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < int'(tbl[i].n); j++)
        send_pair(tbl[i].a[j], tbl[i].b[j], (j == int'(tbl[i].n) - 1), 1'b1);
      get_result(tbl[i].e, $sformatf("tbl%0d", i));
    end

    // Backpressure: result 9 held while the next vector waits at the input.
    send_pair(8'd3, 8'd3, 1'b1, 1'b0);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = ov0;
      @(posedge clk);
      #1;
    end
    if (!seen) fail_now("bp_result");
    in_valid = 1'b1; in_a = 8'd2; in_b = 8'd5; in_last = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", longint'(ir0), 0);
      check("bp_valid", longint'(ov0), 1);
      for (int c = 0; c < 3; c++) check("bp_data_stable", got_d(c), 9);
      @(posedge clk);
      #1;
    end
    send_pair(8'd2, 8'd5, 1'b0, 1'b1);
    send_pair(8'd2, 8'd5, 1'b1, 1'b1);
    e = tbl[8].e;
    get_result(e, "bp_next");

    // Reset mid-vector discards the partial sum.
    send_pair(8'd10, 8'd10, 1'b0, 1'b1);
    send_pair(8'd10, 8'd10, 1'b0, 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      check("midrst_valid", longint'(got_v(c)), 0);
      check("midrst_data", got_d(c), 0);
    end
    check("midrst_in_ready", longint'(ir0), 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("postrst_valid", longint'(ov0), 0);
    check("postrst_data", got_d(0), 0);
    @(posedge clk);
    #1;
    send_pair(8'd2, 8'd3, 1'b1, 1'b1);
    e = '0;
    for (int c = 0; c < 3; c++) e.d[c] = 32'd6;
    get_result(e, "postrst");

    // Back-to-back vectors with bubbles, scored by the reference model.
    for (int c = 0; c < 3; c++) begin macc[c] = 0; mst[c] = 1'b0; end
    mdl_en = 1'b1;
    send_pair(8'd1, 8'd1, 1'b1, 1'b1);
    gap();
    send_pair(8'd4, 8'd2, 1'b0, 1'b1);
    gap();
    send_pair(8'hfc, 8'd2, 1'b1, 1'b1);
    repeat (8) cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
    check("b2b_drained", exp_q.size(), 0);

    // Random traffic with bubbles, backpressure and biased extreme operands.
    repeat (1500) begin
      ra = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 8'h7f : 8'h80) : 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 8'h7f : 8'h80) : 8'($urandom);
      cycle($urandom_range(0, 3) != 0, ra, rb, $urandom_range(0, 5) == 0,
            $urandom_range(0, 3) != 0, acc);
    end
    repeat (10) cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
    check("rand_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
